pdm_byte_receiver: RTL and testbench

- Receive-side counterpart to the audio input latch.
- Generates the microphone bit clock (mic_clk), synchronises and samples the 1-bit serial stream (mic_data), undoes the transmit-side inversion, and packs WIDTH bits MSB-first into a word.
- Hands each word to the audio datapath over a valid/ready handshake and flags any word lost to backpressure.

---
 rtl/pdm_byte_receiver_pkg.sv | 8 +
 rtl/pdm_byte_receiver_clk_gen.sv | 30 +++
 rtl/pdm_byte_receiver.sv | 74 +++++++
 tb/tb_pdm_byte_receiver.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pdm_byte_receiver_pkg.sv
// Shared audio definitions: receiver FSM states and the polarity/width defaults
// that the transmit side also uses, so both ends agree on bit inversion.
package pdm_byte_receiver_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_WIDTH  = 8;
  localparam bit DEF_INVERT = 1'b1;
endpackage

// File: rtl/pdm_byte_receiver_clk_gen.sv
// Microphone bit-clock divider. mic_clk toggles every CLK_DIV cycles while run
// is high; strobe marks the last cycle of the high phase (the sample point).
module mic_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mic_clk,
  output logic strobe
);
  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt     <= '0;
      mic_clk <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      mic_clk <= ~mic_clk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign strobe = run && mic_clk && (cnt == LAST);
endmodule

// File: rtl/pdm_byte_receiver.sv
// PDM byte receiver: generates mic_clk, synchronises and samples mic_data,
// packs WIDTH bits MSB-first and offers each word on a valid/ready port.
module pdm_byte_receiver
  import pdm_byte_receiver_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit INVERT  = DEF_INVERT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mic_data,
  output logic             mic_clk,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);
  localparam int            BW       = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [1:0]       sync_q;
  logic [WIDTH-1:0] shift;
  logic [BW-1:0]    bit_cnt;
  logic             strobe;
  logic             b;
  logic             done;

  mic_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .run     (en),
    .mic_clk (mic_clk),
    .strobe  (strobe)
  );

  assign b    = sync_q[1] ^ INVERT;
  assign done = strobe && (state == RUN) && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sync_q   <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], mic_data};
      state  <= en ? RUN : IDLE;

      // Dropping en discards the partial word; the output side is untouched.
      if (!en || state == IDLE) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (strobe) begin
        shift   <= {shift[WIDTH-2:0], b};
        bit_cnt <= done ? '0 : bit_cnt + 1'b1;
      end

      // A completing word wins over a concurrent take, keeping valid high.
      if (done) begin
        data_out <= {shift[WIDTH-2:0], b};
        valid    <= 1'b1;
        if (valid && !ready) overrun <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pdm_byte_receiver.sv
// Directed bench for pdm_byte_receiver with CLK_DIV=2, WIDTH=8, INVERT=1:
// one bit per 4 clk cycles, first word complete 32 cycles after en rises.
module tb_pdm_byte_receiver;
  logic       clk = 1'b0;
  logic       reset, en, mic_data, ready;
  logic       mic_clk, valid, overrun;
  logic [7:0] data_out;
  int         checks = 0;
  int         errors = 0;

  pdm_byte_receiver #(.CLK_DIV(2), .WIDTH(8), .INVERT(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mic_data (mic_data),
    .mic_clk  (mic_clk),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each bit is driven while mic_clk is low so it has cleared the
  // synchroniser before the sample edge at the end of the high phase.
  task automatic send_bits(input logic [7:0] raw, input int first, input int n);
    logic [7:0] r;
    r = raw;
    for (int i = 0; i < n; i++) begin
      mic_data = r[7 - first - i];
      wait_clk(4);
    end
  endtask

  task automatic restart();
    en = 1'b0;
    wait_clk(2);
    en = 1'b1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mic_data = 1'b0; ready = 1'b0;

    // Reset held with en high
    for (int c = 0; c < 3; c++) begin
      wait_clk(1);
      check("rst_mic_clk", {7'd0, mic_clk}, 8'h00);
      check("rst_valid", {7'd0, valid}, 8'h00);
      check("rst_data", data_out, 8'h00);
      check("rst_overrun", {7'd0, overrun}, 8'h00);
    end
    reset = 1'b0; en = 1'b0;
    wait_clk(2);

    // Single word, raw 0x5A -> 0xA5, valid exactly 32 cycles after en
    ready = 1'b1;
    en = 1'b1;
    wait_clk(1);
    check("first_mic_clk_low", {7'd0, mic_clk}, 8'h00);
    wait_clk(1);
    check("first_mic_clk_rise", {7'd0, mic_clk}, 8'h01);
    mic_data = 1'b0;
    wait_clk(2);
    send_bits(8'h5A, 1, 6);
    mic_data = 1'b0;
    wait_clk(3);
    check("single_not_early", {7'd0, valid}, 8'h00);
    wait_clk(1);
    check("single_valid", {7'd0, valid}, 8'h01);
    check("single_data", data_out, 8'hA5);
    wait_clk(1);
    check("single_taken", {7'd0, valid}, 8'h00);

    // Backpressure and overrun
    ready = 1'b0;
    restart();
    send_bits(8'hC3, 0, 8);
    check("bp_valid1", {7'd0, valid}, 8'h01);
    check("bp_data1", data_out, 8'h3C);
    check("bp_ovr0", {7'd0, overrun}, 8'h00);
    send_bits(8'h3C, 0, 4);
    check("bp_hold_data", data_out, 8'h3C);
    check("bp_hold_valid", {7'd0, valid}, 8'h01);
    send_bits(8'h3C, 4, 4);
    check("bp_data2", data_out, 8'hC3);
    check("bp_overrun", {7'd0, overrun}, 8'h01);
    ready = 1'b1;
    wait_clk(1);
    check("bp_taken", {7'd0, valid}, 8'h00);
    wait_clk(3);
    check("bp_ovr_sticky", {7'd0, overrun}, 8'h01);
    reset = 1'b1; en = 1'b0;
    wait_clk(1);
    reset = 1'b0;
    check("bp_ovr_cleared", {7'd0, overrun}, 8'h00);

    // Take and completion on the same edge
    ready = 1'b0;
    restart();
    send_bits(8'hF0, 0, 8);
    check("sim_data1", data_out, 8'h0F);
    send_bits(8'h0F, 0, 7);
    mic_data = 1'b1;
    wait_clk(3);
    ready = 1'b1;
    wait_clk(1);
    check("sim_data2", data_out, 8'hF0);
    check("sim_valid", {7'd0, valid}, 8'h01);
    check("sim_no_ovr", {7'd0, overrun}, 8'h00);
    wait_clk(1);
    check("sim_taken", {7'd0, valid}, 8'h00);

    // Enable drop after 5 bits discards the partial word
    restart();
    send_bits(8'hA8, 0, 5);
    en = 1'b0;
    wait_clk(1);
    check("en_off_mic_clk", {7'd0, mic_clk}, 8'h00);
    wait_clk(3);
    check("en_off_mic_clk2", {7'd0, mic_clk}, 8'h00);
    check("en_off_valid", {7'd0, valid}, 8'h00);
    en = 1'b1;
    send_bits(8'h00, 0, 7);
    mic_data = 1'b0;
    wait_clk(3);
    check("en_not_early", {7'd0, valid}, 8'h00);
    wait_clk(1);
    check("en_valid", {7'd0, valid}, 8'h01);
    check("en_data", data_out, 8'hFF);

    // Reset after 4 bits; next word starts from bit 0
    restart();
    send_bits(8'hFF, 0, 4);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    check("midrst_valid", {7'd0, valid}, 8'h00);
    check("midrst_data", data_out, 8'h00);
    check("midrst_mic_clk", {7'd0, mic_clk}, 8'h00);
    send_bits(8'h96, 0, 8);
    check("midrst_word_valid", {7'd0, valid}, 8'h01);
    check("midrst_word_data", data_out, 8'h69);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
